// File: rtl/native_axi_pkg.sv
// rtl/native_axi_pkg.sv - shared types and encodings for the native-to-AXI line bridge
package native_axi_pkg;

  // Bridge FSM states; one cache line per AXI transaction.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD_ADDR = 3'd4,
    ST_RD_DATA = 3'd5,
    ST_RD_RET  = 3'd6
  } nat_axi_state_t;

  // Native request opcodes; any other encoding is accepted and dropped.
  localparam logic [1:0] NAT_OP_READ  = 2'b01;
  localparam logic [1:0] NAT_OP_WRITE = 2'b10;

  // AXI encodings used by the bridge.
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/native_to_axi.sv
// rtl/native_to_axi.sv - native line request/update port to AXI4 master bridge (optional NATIVE_AXI_RESP_CHECK_EN)
module native_to_axi #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 256,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  // native request channel
  input  logic                        nat_request_valid,
  output logic                        nat_request_ready,
  input  logic [1:0]                  nat_request_op,
  input  logic [ADDR_WIDTH-1:0]       nat_request_addr,
  input  logic [LINE_WIDTH-1:0]       nat_request_data,
  // native update (read return) channel
  output logic                        nat_update_valid,
  input  logic                        nat_update_ready,
  output logic [LINE_WIDTH-1:0]       nat_update_data,
  // AXI write address
  output logic                        m_awvalid,
  input  logic                        m_awready,
  output logic [ADDR_WIDTH-1:0]       m_awaddr,
  output logic [7:0]                  m_awlen,
  output logic [2:0]                  m_awsize,
  output logic [1:0]                  m_awburst,
  // AXI write data
  output logic                        m_wvalid,
  input  logic                        m_wready,
  output logic [AXI_DATA_WIDTH-1:0]   m_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_wstrb,
  output logic                        m_wlast,
  // AXI write response
  input  logic                        m_bvalid,
  output logic                        m_bready,
  input  logic [1:0]                  m_bresp,
  // AXI read address
  output logic                        m_arvalid,
  input  logic                        m_arready,
  output logic [ADDR_WIDTH-1:0]       m_araddr,
  output logic [7:0]                  m_arlen,
  output logic [2:0]                  m_arsize,
  output logic [1:0]                  m_arburst,
  // AXI read data
  input  logic                        m_rvalid,
  output logic                        m_rready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]                  m_rresp,
  input  logic                        m_rlast,
  // sticky response error
  output logic                        axi_error
);

  import native_axi_pkg::*;

  localparam int BEATS    = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);

  localparam logic [7:0]            LAST_BEAT = 8'(BEATS - 1);
  localparam logic [2:0]            AXI_SIZE  = 3'($clog2(AXI_DATA_WIDTH / 8));
  // Clears the byte-within-line bits so every burst starts on a line boundary.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);

  nat_axi_state_t            state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [LINE_WIDTH-1:0]     line_q, line_d;
  logic [31:0]               bit_off;
  logic                      last_beat;

  // Bit offset of the current beat inside the line; beat 0 is the low slice.
  assign bit_off   = 32'(cnt_q) * 32'(AXI_DATA_WIDTH);
  assign last_beat = (cnt_q == LAST_BEAT);

  // State, beat counter and line/address registers; reset abandons any burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

  // Next-state, counter and line assembly; beats only advance on a handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    unique case (state_q)
      ST_IDLE: begin
        if (nat_request_valid) begin
          addr_d = nat_request_addr & LINE_MASK;
          line_d = nat_request_data;
          cnt_d  = '0;
          if (nat_request_op == NAT_OP_WRITE) begin
            state_d = ST_WR_ADDR;
          end else if (nat_request_op == NAT_OP_READ) begin
            state_d = ST_RD_ADDR;
          end
        end
      end
      ST_WR_ADDR: begin
        if (m_awready) begin
          state_d = ST_WR_DATA;
          cnt_d   = '0;
        end
      end
      ST_WR_DATA: begin
        if (m_wready) begin
          if (last_beat) begin
            state_d = ST_WR_RESP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_WR_RESP: begin
        if (m_bvalid) begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (m_arready) begin
          state_d = ST_RD_DATA;
          cnt_d   = '0;
        end
      end
      ST_RD_DATA: begin
        if (m_rvalid) begin
          line_d[bit_off +: AXI_DATA_WIDTH] = m_rdata;
          // Completion is counted, so a misplaced rlast cannot end the burst early.
          if (last_beat) begin
            state_d = ST_RD_RET;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_RD_RET: begin
        if (nat_update_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Handshake outputs decode directly from the registered state.
  assign nat_request_ready = (state_q == ST_IDLE) && !rst;
  assign m_awvalid         = (state_q == ST_WR_ADDR);
  assign m_wvalid          = (state_q == ST_WR_DATA);
  assign m_bready          = (state_q == ST_WR_RESP);
  assign m_arvalid         = (state_q == ST_RD_ADDR);
  assign m_rready          = (state_q == ST_RD_DATA);
  assign nat_update_valid  = (state_q == ST_RD_RET);

  // Address channels come from the latched address so they hold until acknowledged.
  assign m_awaddr  = addr_q;
  assign m_awlen   = LAST_BEAT;
  assign m_awsize  = AXI_SIZE;
  assign m_awburst = AXI_BURST_INCR;
  assign m_araddr  = addr_q;
  assign m_arlen   = LAST_BEAT;
  assign m_arsize  = AXI_SIZE;
  assign m_arburst = AXI_BURST_INCR;

  // Write beats are sliced out of the latched line in ascending order.
  assign m_wdata = line_q[bit_off +: AXI_DATA_WIDTH];
  assign m_wstrb = '1;
  assign m_wlast = (state_q == ST_WR_DATA) && last_beat;

  assign nat_update_data = line_q;

`ifdef NATIVE_AXI_RESP_CHECK_EN
  logic err_q, err_d;

  // Any non-OKAY response or misplaced rlast latches the error until reset.
  always_comb begin
    err_d = err_q;
    if ((state_q == ST_WR_RESP) && m_bvalid && (m_bresp != AXI_RESP_OKAY)) begin
      err_d = 1'b1;
    end
    if ((state_q == ST_RD_DATA) && m_rvalid &&
        ((m_rresp != AXI_RESP_OKAY) || (m_rlast != last_beat))) begin
      err_d = 1'b1;
    end
  end

  // Sticky error register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign axi_error = err_q;
`else
  // Responses and rlast carry no meaning for the bridge without checking.
  logic unused_resp;
  assign unused_resp = ^{m_bresp, m_rresp, m_rlast};
  assign axi_error   = 1'b0;
`endif

endmodule

// File: tb/tb_native_to_axi.sv
// tb/tb_native_to_axi.sv - directed self-checking bench for native_to_axi
module tb_native_to_axi;

  logic         clk;
  logic         rst;
  logic         nat_request_valid;
  logic         nat_request_ready;
  logic [1:0]   nat_request_op;
  logic [31:0]  nat_request_addr;
  logic [255:0] nat_request_data;
  logic         nat_update_valid;
  logic         nat_update_ready;
  logic [255:0] nat_update_data;
  logic         m_awvalid, m_awready;
  logic [31:0]  m_awaddr;
  logic [7:0]   m_awlen;
  logic [2:0]   m_awsize;
  logic [1:0]   m_awburst;
  logic         m_wvalid, m_wready;
  logic [63:0]  m_wdata;
  logic [7:0]   m_wstrb;
  logic         m_wlast;
  logic         m_bvalid, m_bready;
  logic [1:0]   m_bresp;
  logic         m_arvalid, m_arready;
  logic [31:0]  m_araddr;
  logic [7:0]   m_arlen;
  logic [2:0]   m_arsize;
  logic [1:0]   m_arburst;
  logic         m_rvalid, m_rready;
  logic [63:0]  m_rdata;
  logic [1:0]   m_rresp;
  logic         m_rlast;
  logic         axi_error;

  int n_cmp = 0;
  int n_bad = 0;

  native_to_axi dut (
    .clk(clk), .rst(rst),
    .nat_request_valid(nat_request_valid), .nat_request_ready(nat_request_ready),
    .nat_request_op(nat_request_op), .nat_request_addr(nat_request_addr),
    .nat_request_data(nat_request_data),
    .nat_update_valid(nat_update_valid), .nat_update_ready(nat_update_ready),
    .nat_update_data(nat_update_data),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .axi_error(axi_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Read one line; memory returns beats base+0..base+3. hold = cycles update_ready
  // stays low. abort_beat >= 0 asserts rst while that beat is being offered.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [7:0] base, input int hold, input int abort_beat);
    logic [255:0] exp_line;
    exp_line = '0;
    for (int k = 0; k < 4; k++) exp_line[k*64 +: 64] = {56'h0, base + 8'(k)};
    check_eq("rd_req_ready", nat_request_ready, 1'b1);
    nat_request_valid = 1'b1;
    nat_request_op    = 2'b01;
    nat_request_addr  = addr;
    tick;                               // accept edge; now cycle N+1
    nat_request_valid = 1'b0;
    nat_request_op    = 2'b00;
    check_eq("rd_arvalid", m_arvalid, 1'b1);
    check_eq("rd_araddr", m_araddr, exp_addr);
    check_eq("rd_arlen", m_arlen, 8'd3);
    check_eq("rd_arsize", m_arsize, 3'd3);
    check_eq("rd_arburst", m_arburst, 2'b01);
    check_eq("rd_awvalid_idle", m_awvalid, 1'b0);
    m_arready = 1'b1;
    tick;                               // cycle N+2: first beat
    check_eq("rd_arvalid_drop", m_arvalid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k == abort_beat) begin
        rst = 1'b1;
        #1;
        check_eq("rst_rready", m_rready, 1'b0);
        check_eq("rst_arvalid", m_arvalid, 1'b0);
        check_eq("rst_awvalid", m_awvalid, 1'b0);
        check_eq("rst_wvalid", m_wvalid, 1'b0);
        check_eq("rst_bready", m_bready, 1'b0);
        check_eq("rst_upd_valid", nat_update_valid, 1'b0);
        check_eq("rst_req_ready", nat_request_ready, 1'b0);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        return;
      end
      check_eq("rd_rready", m_rready, 1'b1);
      check_eq("rd_upd_early", nat_update_valid, 1'b0);
      m_rvalid = 1'b1;
      m_rdata  = {56'h0, base + 8'(k)};
      m_rlast  = (k == 3);
      tick;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    // cycle N+6
    check_eq("rd_upd_valid", nat_update_valid, 1'b1);
    check_eq("rd_upd_data", nat_update_data, exp_line);
    check_eq("rd_rready_drop", m_rready, 1'b0);
    for (int h = 0; h < hold; h++) begin
      tick;
      check_eq("hold_upd_valid", nat_update_valid, 1'b1);
      check_eq("hold_upd_data", nat_update_data, exp_line);
      check_eq("hold_req_ready", nat_request_ready, 1'b0);
    end
    nat_update_ready = 1'b1;
    tick;
    nat_update_ready = 1'b0;
    check_eq("rd_done_upd", nat_update_valid, 1'b0);
    check_eq("rd_done_ready", nat_request_ready, 1'b1);
  endtask

  // Write line {D3..D0} with wready toggling 1/0, then answer with bresp.
  task automatic do_write(input logic [31:0] addr, input logic [1:0] bresp);
    logic [63:0] beats [4];
    logic [255:0] line;
    int beat;
    beats[0] = 64'hD0D0_0000_0000_00D0;
    beats[1] = 64'hD1D1_1111_0000_00D1;
    beats[2] = 64'hD2D2_2222_0000_00D2;
    beats[3] = 64'hD3D3_3333_0000_00D3;
    line = {beats[3], beats[2], beats[1], beats[0]};
    check_eq("wr_req_ready", nat_request_ready, 1'b1);
    nat_request_valid = 1'b1;
    nat_request_op    = 2'b10;
    nat_request_addr  = addr;
    nat_request_data  = line;
    tick;
    nat_request_valid = 1'b0;
    nat_request_op    = 2'b00;
    nat_request_data  = '0;
    check_eq("wr_awvalid", m_awvalid, 1'b1);
    check_eq("wr_awaddr", m_awaddr, addr & 32'hFFFF_FFE0);
    check_eq("wr_awlen", m_awlen, 8'd3);
    check_eq("wr_awsize", m_awsize, 3'd3);
    check_eq("wr_awburst", m_awburst, 2'b01);
    m_awready = 1'b1;
    tick;
    m_awready = 1'b0;
    beat = 0;
    for (int i = 0; i < 20 && beat < 4; i++) begin
      m_wready = (i % 2 == 0);
      check_eq("wr_wvalid", m_wvalid, 1'b1);
      check_eq("wr_no_upd", nat_update_valid, 1'b0);
      check_eq("wr_wdata", m_wdata, beats[beat]);
      check_eq("wr_wlast", m_wlast, beat == 3);
      check_eq("wr_wstrb", m_wstrb, 8'hFF);
      if (m_wready) beat++;
      tick;
    end
    m_wready = 1'b0;
    check_eq("wr_beats_done", beat, 4);
    check_eq("wr_wvalid_drop", m_wvalid, 1'b0);
    check_eq("wr_bready", m_bready, 1'b1);
    check_eq("wr_resp_req_ready", nat_request_ready, 1'b0);
    m_bvalid = 1'b1;
    m_bresp  = bresp;
    tick;
    m_bvalid = 1'b0;
    m_bresp  = 2'b00;
    check_eq("wr_done_bready", m_bready, 1'b0);
    check_eq("wr_done_ready", nat_request_ready, 1'b1);
    check_eq("wr_done_no_upd", nat_update_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    nat_request_valid = 1'b0; nat_request_op = 2'b00;
    nat_request_addr = '0; nat_request_data = '0;
    nat_update_ready = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0;
    tick;
    tick;
    check_eq("reset_req_ready", nat_request_ready, 1'b0);
    check_eq("reset_awvalid", m_awvalid, 1'b0);
    check_eq("reset_arvalid", m_arvalid, 1'b0);
    check_eq("reset_upd_valid", nat_update_valid, 1'b0);
    check_eq("reset_axi_error", axi_error, 1'b0);
    rst = 1'b0;
    tick;
    check_eq("post_reset_ready", nat_request_ready, 1'b1);

    // Plain read, no stalls.
    do_read(32'h1234_5678, 32'h1234_5660, 8'hA0, 0, -1);

    // Write with wready toggling.
    do_write(32'h0000_0040, 2'b00);

    // No-op opcodes are accepted and dropped; IDLE every cycle.
    nat_request_valid = 1'b1;
    nat_request_op    = 2'b00;
    nat_request_addr  = 32'h0000_0080;
    check_eq("noop0_ready", nat_request_ready, 1'b1);
    tick;
    nat_request_op = 2'b11;
    check_eq("noop0_awvalid", m_awvalid, 1'b0);
    check_eq("noop0_arvalid", m_arvalid, 1'b0);
    check_eq("noop0_next_ready", nat_request_ready, 1'b1);
    tick;
    nat_request_valid = 1'b0;
    nat_request_op    = 2'b00;
    check_eq("noop3_awvalid", m_awvalid, 1'b0);
    check_eq("noop3_arvalid", m_arvalid, 1'b0);
    check_eq("noop3_ready", nat_request_ready, 1'b1);

    // Read with update backpressure for 5 cycles.
    do_read(32'h0000_0abc, 32'h0000_0aa0, 8'hB0, 5, -1);

    // Reset in the middle of read beat 2, then a fresh read.
    do_read(32'h0000_0100, 32'h0000_0100, 8'hC0, 0, 2);
    tick;
    rst = 1'b0;
    tick;
    check_eq("after_rst_ready", nat_request_ready, 1'b1);
    do_read(32'h0000_021f, 32'h0000_0200, 8'hE0, 0, -1);

`ifdef NATIVE_AXI_RESP_CHECK_EN
    check_eq("err_clean", axi_error, 1'b0);
    do_write(32'h0000_0300, 2'b10);
    check_eq("err_set", axi_error, 1'b1);
    do_read(32'h0000_0400, 32'h0000_0400, 8'h10, 0, -1);
    check_eq("err_sticky", axi_error, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    check_eq("err_cleared", axi_error, 1'b0);
`else
    do_write(32'h0000_0300, 2'b10);
    check_eq("err_tied_low", axi_error, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
